tty_tx_ctrl: RTL and testbench

//  Transmit controller for the MCU TTY port. Buffers 7-bit characters written by the core
//  (tty data + one-cycle write strobe) in a FIFO, then serialises them on one UART line
//  (8N1, LSB first, bit 7 forced 0). Sits between the mcu tty_o/tty_we_o outputs and the

---
 rtl/tty_tx_ctrl.sv | 174 +++++++++++++++++
 tb/tb_tty_tx_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tty_tx_ctrl.sv
// TTY transmit controller: buffers 7-bit characters in a FIFO and sends them as 8N1 UART frames.
// Define TTY_TX_CTS_EN to add the active-low cts_in flow-control input.
module tty_tx_ctrl #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_in,
  input  logic [6:0] tty_i,
  input  logic       tty_we_i,
  output logic       full_o,
  output logic       busy_o,
  output logic       drop_o,
  output logic       tx_o
`ifdef TTY_TX_CTS_EN
  ,
  input  logic       cts_in
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, drop_q, full_q;

  logic [6:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop, clear, non_empty;

`ifdef TTY_TX_CTS_EN
  logic cts_meta_q, cts_sync_q;

  // Resets to "not clear" so nothing leaves before the line partner is seen.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts_in;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign clear = ~cts_sync_q;
`else
  assign clear = 1'b1;
`endif

  assign non_empty = (count_q != '0);
  assign push      = tty_we_i && !full_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tty_i;
    end
  end

  // tx_d is decoded from the current state, so the line trails the FSM by one cycle.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (non_empty && clear) begin
          pop     = 1'b1;
          shift_d = {1'b0, mem_q[rd_ptr_q]};
          div_d   = DivLast;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (div_q == '0) begin
          div_d   = DivLast;
          bit_d   = '0;
          state_d = StData;
        end else begin
          div_d = div_q - DivW'(1);
        end
      end
      StData: begin
        tx_d = shift_q[bit_q];
        if (div_q == '0) begin
          div_d = DivLast;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          div_d = div_q - DivW'(1);
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (div_q == '0) begin
          if (non_empty && clear) begin
            pop     = 1'b1;
            shift_d = {1'b0, mem_q[rd_ptr_q]};
            div_d   = DivLast;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          div_d = div_q - DivW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
      full_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= (state_q != StIdle) || non_empty;
      drop_q  <= tty_we_i && full_q;
      full_q  <= (count_d == CntFull);
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign drop_o = drop_q;
  assign full_o = full_q;

endmodule

// File: tb/tb_tty_tx_ctrl.sv
// Bench for tty_tx_ctrl (CLK_DIV=4, FIFO_DEPTH=8): frame table, directed corner sequences and
// random traffic compared cycle by cycle against a queue-based model of the serial line.
`timescale 1ns/1ps
module tb_tty_tx_ctrl;
  localparam int unsigned Div   = 4;
  localparam int unsigned Depth = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] tty;
  logic       tty_we;
  logic       full, busy, drop, tx;
`ifdef TTY_TX_CTS_EN
  logic       cts;
`endif

  always #5 clk = ~clk;

  tty_tx_ctrl #(
    .CLK_DIV    (Div),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk_i    (clk),
    .rst_in   (rst_n),
    .tty_i    (tty),
    .tty_we_i (tty_we),
    .full_o   (full),
    .busy_o   (busy),
    .drop_o   (drop),
    .tx_o     (tx)
`ifdef TTY_TX_CTS_EN
    ,
    .cts_in   (cts)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: character queue, frame countdown and a queue of future line levels.
  logic [6:0] m_fifo[$];
  bit         m_line[$];
  bit         m_active;
  int         m_rem;
  bit [1:0]   m_sync;
  logic       e_tx, e_busy, e_full, e_drop;

  typedef struct {
    logic [6:0] ch;
    logic [9:0] frame;  // line level per bit, index 0 = start bit
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_line.delete();
    m_active = 1'b0;
    m_rem    = 0;
    m_sync   = 2'b11;
    e_tx     = 1'b1;
    e_busy   = 1'b0;
    e_full   = 1'b0;
    e_drop   = 1'b0;
  endtask

  task automatic model_edge(input bit we, input logic [6:0] ch, input bit cts_now);
    int         sz;
    bit         clr, pop, push, v;
    logic [6:0] c;
    sz = m_fifo.size();
`ifdef TTY_TX_CTS_EN
    clr    = !m_sync[1];
    m_sync = {m_sync[0], cts_now};
`else
    clr = cts_now | 1'b1;
`endif
    push   = we && (sz != Depth);
    e_drop = we && (sz == Depth);
    e_busy = m_active || (sz != 0);
    if (m_line.size() != 0) e_tx = m_line.pop_front();
    else e_tx = 1'b1;
    pop = 1'b0;
    if (!m_active || m_rem == 1) begin
      pop      = (sz != 0) && clr;
      m_active = pop;
    end else begin
      m_rem--;
    end
    if (pop) begin
      c     = m_fifo.pop_front();
      m_rem = 10 * Div;
      for (int b = 0; b < 10; b++) begin
        if (b == 0 || b == 8) v = 1'b0;
        else if (b == 9) v = 1'b1;
        else v = c[b-1];
        for (int k = 0; k < Div; k++) m_line.push_back(v);
      end
    end
    if (push) m_fifo.push_back(ch);
    e_full = (m_fifo.size() == Depth);
  endtask

  // Drive one cycle of input, let the edge happen, then compare all outputs with the model.
  task automatic tick(input bit we, input logic [6:0] ch);
    bit cts_now;
    cts_now = 1'b0;
`ifdef TTY_TX_CTS_EN
    cts_now = cts;
`endif
    tty_we = we;
    tty    = we ? ch : 7'bx;
    @(posedge clk);
    model_edge(we, ch, cts_now);
    #1;
    cyc++;
    check("tx", tx, e_tx);
    check("busy", busy, e_busy);
    check("full", full, e_full);
    check("drop", drop, e_drop);
    tty_we = 1'b0;
  endtask

  // Asynchronous reset mid-cycle: outputs must settle without any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_drop", drop, 1'b0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int   pct;
    int   waited;
    logic exp_bit;

    vecs[0] = '{7'h41, 10'b1010000010};
    vecs[1] = '{7'h55, 10'b1010101010};
    vecs[2] = '{7'h2A, 10'b1001010100};
    vecs[3] = '{7'h30, 10'b1001100000};
    vecs[4] = '{7'h7F, 10'b1011111110};
    vecs[5] = '{7'h00, 10'b1000000000};

    rst_n  = 1'b0;
    tty_we = 1'b0;
    tty    = '0;
`ifdef TTY_TX_CTS_EN
    cts    = 1'b0;
`endif
    #23;
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_full", full, 1'b0);
    check("reset_drop", drop, 1'b0);
    model_reset();
    rst_n = 1'b1;
    repeat (3) tick(1'b0, '0);

    // Single characters: fixed latency, exact frame levels, busy falls after the stop bit.
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, vecs[i].ch);
      tick(1'b0, '0);
      check("latency_tx_idle", tx, 1'b1);
      check("latency_busy", busy, 1'b1);
      for (int j = 0; j < 10 * Div; j++) begin
        tick(1'b0, '0);
        check("frame_bit", tx, vecs[i].frame[j/Div]);
      end
      check("busy_last_stop", busy, 1'b1);
      tick(1'b0, '0);
      check("after_frame_tx", tx, 1'b1);
      check("after_frame_busy", busy, 1'b0);
    end

    // Ten writes on consecutive cycles: nine accepted, tenth dropped.
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 7'h10 + 7'(i));
      if (i == 7) check("fill_not_full", full, 1'b0);
      if (i == 8) check("fill_full", full, 1'b1);
      if (i == 9) check("fill_drop", drop, 1'b1);
    end
    tick(1'b0, '0);
    check("drop_single_pulse", drop, 1'b0);
    check("full_held", full, 1'b1);
    repeat (9 * 10 * Div + 10) tick(1'b0, '0);
    check("fill_drained_busy", busy, 1'b0);

    // Back-to-back characters form 80 contiguous cycles of line data.
    tick(1'b1, 7'h55);
    tick(1'b1, 7'h2A);
    for (int j = 0; j < 20 * Div; j++) begin
      tick(1'b0, '0);
      if (j < 10 * Div) exp_bit = vecs[1].frame[j/Div];
      else exp_bit = vecs[2].frame[(j - 10 * Div)/Div];
      check("b2b_bit", tx, exp_bit);
    end
    tick(1'b0, '0);
    check("b2b_busy_end", busy, 1'b0);

    // Reset during the data bits of a frame, then a clean frame follows.
    tick(1'b1, 7'h00);
    repeat (1 + 3 * Div + 1) tick(1'b0, '0);
    check("pre_reset_tx_low", tx, 1'b0);
    do_reset();
    tick(1'b1, 7'h30);
    repeat (10 * Div + 6) tick(1'b0, '0);
    check("post_reset_busy", busy, 1'b0);

`ifdef TTY_TX_CTS_EN
    cts = 1'b1;
    repeat (3) tick(1'b0, '0);
    tick(1'b1, 7'h41);
    repeat (10) tick(1'b0, '0);
    check("cts_hold_tx", tx, 1'b1);
    check("cts_hold_busy", busy, 1'b1);
    cts    = 1'b0;
    waited = 0;
    while (tx === 1'b1 && waited < 8) begin
      tick(1'b0, '0);
      waited++;
    end
    check("cts_start_within_4", waited <= 4, 1'b1);
    repeat (10) tick(1'b0, '0);
    cts = 1'b1;
    tick(1'b1, 7'h22);
    repeat (10 * Div + 10) tick(1'b0, '0);
    check("cts_next_held_tx", tx, 1'b1);
    check("cts_next_held_busy", busy, 1'b1);
    cts = 1'b0;
    repeat (10 * Div + 10) tick(1'b0, '0);
`endif

    // Random traffic in phases of differing write density.
    for (int ph = 0; ph < 4; ph++) begin
      if (ph == 0) pct = 50;
      else if (ph == 1) pct = 5;
      else if (ph == 2) pct = 90;
      else pct = 20;
      for (int n = 0; n < 1500; n++) begin
`ifdef TTY_TX_CTS_EN
        if ($urandom_range(99) < 2) cts = ~cts;
`endif
        if (ph == 2 && n == 700) do_reset();
        tick($urandom_range(99) < pct, 7'($urandom));
      end
    end
`ifdef TTY_TX_CTS_EN
    cts = 1'b0;
`endif
    repeat ((Depth + 2) * 10 * Div) tick(1'b0, '0);
    check("final_idle_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
